// File: rtl/paddle_input_conditioner.sv
`timescale 1ns/1ps
// paddle_input_conditioner
//   Turns the four raw paddle push-buttons into one-cycle move-enable pulses
//   for the game core. Each button is polarity-normalised, synchronised,
//   debounced, and then drives a press/auto-repeat pulse generator. When both
//   directions of one paddle are held, that paddle's pulses are suppressed.
//   A game-level enable holds every repeat generator idle.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   enable           1 = game running, 0 = no pulses, repeat generators idle
//   btnRaw[3:0]      raw buttons {rightDown, rightUp, leftDown, leftUp}, async
//   leftPaddleUp     one-cycle move pulse, left paddle up
//   leftPaddleDown   one-cycle move pulse, left paddle down
//   rightPaddleUp    one-cycle move pulse, right paddle up
//   rightPaddleDown  one-cycle move pulse, right paddle down
//   btnHeld[3:0]     debounced pressed level, same bit order as btnRaw
module paddle_input_conditioner #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btnRaw,
    output logic       leftPaddleUp,
    output logic       leftPaddleDown,
    output logic       rightPaddleUp,
    output logic       rightPaddleDown,
    output logic [3:0] btnHeld
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Compare values are "one before the target" because the counter is
    // checked before it would be incremented to the target.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [3:0]       btn_norm;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q [4];
    logic [CNT_W-1:0] deb_cnt_d [4];
    logic [1:0]       state_q [4];
    logic [1:0]       state_d [4];
    logic [CNT_W-1:0] rep_cnt_q [4];
    logic [CNT_W-1:0] rep_cnt_d [4];
    logic [3:0]       pulse_q, pulse_d;
    logic             left_conflict;
    logic             right_conflict;

    // Normalise so that internally pressed = 1; released therefore resets to 0.
    always_comb begin
        btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btnRaw : btnRaw;
        sync1_d  = btn_norm;
        sync2_d  = sync1_q;
    end

    // Debounce: count consecutive cycles the synchronised input disagrees
    // with the accepted level; accept the new level on the last one.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press / auto-repeat generator. Release or disable overrides any pulse.
    always_comb begin
        pulse_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            if (!deb_q[i] || !enable) begin
                state_d[i]   = ST_IDLE;
                rep_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        pulse_d[i]   = 1'b1;
                        rep_cnt_d[i] = '0;
                        state_d[i]   = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (rep_cnt_q[i] == DELAY_LAST) begin
                            pulse_d[i]   = 1'b1;
                            rep_cnt_d[i] = '0;
                            state_d[i]   = ST_REPEAT;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rep_cnt_q[i] == PERIOD_LAST) begin
                            pulse_d[i]   = 1'b1;
                            rep_cnt_d[i] = '0;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i]   = ST_IDLE;
                        rep_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pulse_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= ST_IDLE;
                rep_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
            for (int unsigned i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    // Conflict masking is applied on the output only, so both generators of a
    // conflicted paddle keep their own phase for when one side is released.
    always_comb begin
        left_conflict   = deb_q[0] & deb_q[1];
        right_conflict  = deb_q[2] & deb_q[3];
        leftPaddleUp    = pulse_q[0] & ~left_conflict;
        leftPaddleDown  = pulse_q[1] & ~left_conflict;
        rightPaddleUp   = pulse_q[2] & ~right_conflict;
        rightPaddleDown = pulse_q[3] & ~right_conflict;
        btnHeld         = deb_q;
    end

endmodule
